// File: rtl/y86_pkg.sv
// Shared constants for the SEQ Y86-64 core: instruction codes, register IDs, status codes.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] REG_RSP  = 4'h4;
  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {
    S_AOK = 2'd0,
    S_HLT = 2'd1,
    S_ADR = 2'd2,
    S_INS = 2'd3
  } stat_t;

endpackage

// File: rtl/regfile_2r2w.sv
// 15 x DATA_W register file: two async read ports, two sync write ports (M wins
// over E on the same ID), async reset with %rsp preset, and a debug read port.
module regfile_2r2w
  import y86_pkg::*;
#(
  parameter int              DATA_W   = 64,
  parameter int              NREG     = 15,
  parameter logic [DATA_W-1:0] RSP_INIT = 64'd1000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        src_a,
  input  logic [3:0]        src_b,
  output logic [DATA_W-1:0] val_a,
  output logic [DATA_W-1:0] val_b,
  input  logic              we,
  input  logic [3:0]        dst_e,
  input  logic [DATA_W-1:0] val_e,
  input  logic [3:0]        dst_m,
  input  logic [DATA_W-1:0] val_m,
  input  logic [3:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_val
);

  logic [DATA_W-1:0] regs [NREG];

  // Any ID without a backing register (4'hF) reads as zero.
  function automatic logic [DATA_W-1:0] rd(input logic [3:0] id);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < NREG; i++) begin
      if (id == 4'(i)) r = regs[i];
    end
    return r;
  endfunction

  // Combinational reads; no bypass, so a same-cycle write is not visible.
  always_comb begin
    val_a   = rd(src_a);
    val_b   = rd(src_b);
    dbg_val = rd(dbg_sel);
  end

  // Write-back; the M port is assigned last so it wins when both target one ID.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= (4'(i) == REG_RSP) ? RSP_INIT : '0;
      end
    end else if (we) begin
      for (int i = 0; i < NREG; i++) begin
        if (dst_e == 4'(i)) regs[i] <= val_e;
        if (dst_m == 4'(i)) regs[i] <= val_m;
      end
    end
  end

endmodule

// File: rtl/decode_wb_seq.sv
// SEQ Y86-64 decode/write-back: register ID decode, register file, sticky status.
//
// state | meaning
// AOK   | running; write-back enabled for non-faulting instructions
// HLT   | halt seen; writes frozen until reset
// ADR   | address fault; writes frozen until reset
// INS   | invalid instruction; writes frozen until reset
module decode_wb_seq
  import y86_pkg::*;
#(
  parameter int                DATA_W   = 64,
  parameter int                NREG     = 15,
  parameter logic [DATA_W-1:0] RSP_INIT = 64'd1000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        in_code,
  input  logic [3:0]        ra,
  input  logic [3:0]        rb,
  input  logic              flag_halt,
  input  logic              in_error,
  input  logic              bad_mem,
  input  logic              cnd,
  input  logic [DATA_W-1:0] val_e,
  input  logic [DATA_W-1:0] val_m,
  output logic [DATA_W-1:0] val_a,
  output logic [DATA_W-1:0] val_b,
  output logic [3:0]        src_a,
  output logic [3:0]        src_b,
  output logic [3:0]        dst_e,
  output logic [3:0]        dst_m,
  output logic [1:0]        stat,
  input  logic [3:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_val
);

  stat_t stat_q, stat_nxt;
  logic  wr_en;

  // Register ID decode by instruction class.
  always_comb begin
    src_a = REG_NONE;
    src_b = REG_NONE;
    dst_e = REG_NONE;
    dst_m = REG_NONE;
    case (in_code)
      I_RRMOVQ: begin
        src_a = ra;
        dst_e = cnd ? rb : REG_NONE;
      end
      I_IRMOVQ: dst_e = rb;
      I_RMMOVQ: begin
        src_a = ra;
        src_b = rb;
      end
      I_MRMOVQ: begin
        src_b = rb;
        dst_m = ra;
      end
      I_OPQ: begin
        src_a = ra;
        src_b = rb;
        dst_e = rb;
      end
      I_CALL: begin
        src_b = REG_RSP;
        dst_e = REG_RSP;
      end
      I_RET: begin
        src_a = REG_RSP;
        src_b = REG_RSP;
        dst_e = REG_RSP;
      end
      I_PUSHQ: begin
        src_a = ra;
        src_b = REG_RSP;
        dst_e = REG_RSP;
      end
      I_POPQ: begin
        src_a = REG_RSP;
        src_b = REG_RSP;
        dst_e = REG_RSP;
        dst_m = ra;
      end
      default: ;
    endcase
  end

  // Status next-state: priority ADR > INS > HLT; non-AOK states hold.
  always_comb begin
    stat_nxt = stat_q;
    if (stat_q == S_AOK) begin
      if (bad_mem)                              stat_nxt = S_ADR;
      else if (in_error || (in_code > I_POPQ))  stat_nxt = S_INS;
      else if (flag_halt || (in_code == I_HALT)) stat_nxt = S_HLT;
    end
    wr_en = (stat_q == S_AOK) && (stat_nxt == S_AOK);
  end

  // Status register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) stat_q <= S_AOK;
    else       stat_q <= stat_nxt;
  end

  assign stat = stat_q;

  regfile_2r2w #(
    .DATA_W   (DATA_W),
    .NREG     (NREG),
    .RSP_INIT (RSP_INIT)
  ) u_rf (
    .clock   (clock),
    .reset   (reset),
    .src_a   (src_a),
    .src_b   (src_b),
    .val_a   (val_a),
    .val_b   (val_b),
    .we      (wr_en),
    .dst_e   (dst_e),
    .val_e   (val_e),
    .dst_m   (dst_m),
    .val_m   (val_m),
    .dbg_sel (dbg_sel),
    .dbg_val (dbg_val)
  );

endmodule

// File: tb/tb_decode_wb_seq.sv
// Self-checking bench for decode_wb_seq: decode/write-back vector table plus
// hand-written status-latch and reset sequences.
module tb_decode_wb_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  in_code, ra, rb, dbg_sel;
  logic        flag_halt, in_error, bad_mem, cnd;
  logic [63:0] val_e, val_m, val_a, val_b, dbg_val;
  logic [3:0]  src_a, src_b, dst_e, dst_m;
  logic [1:0]  stat;

  decode_wb_seq dut (
    .clock     (clock),
    .reset     (reset),
    .in_code   (in_code),
    .ra        (ra),
    .rb        (rb),
    .flag_halt (flag_halt),
    .in_error  (in_error),
    .bad_mem   (bad_mem),
    .cnd       (cnd),
    .val_e     (val_e),
    .val_m     (val_m),
    .val_a     (val_a),
    .val_b     (val_b),
    .src_a     (src_a),
    .src_b     (src_b),
    .dst_e     (dst_e),
    .dst_m     (dst_m),
    .stat      (stat),
    .dbg_sel   (dbg_sel),
    .dbg_val   (dbg_val)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  ic, ra, rb;
    logic        cnd;
    logic [63:0] ve, vm;
    logic [3:0]  sa, sb, de, dm;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] mdl [15];
  logic [1:0]  mstat;
  int          n_vec = 0;
  int          n_bad = 0;

  logic [63:0] sb_q[$];
  string       sb_n[$];

  function automatic vec_t mk(logic [3:0] ic, logic [3:0] a, logic [3:0] b, logic c,
                              logic [63:0] ve, logic [63:0] vm,
                              logic [3:0] sa, logic [3:0] sb, logic [3:0] de, logic [3:0] dm);
    vec_t v;
    v.ic = ic; v.ra = a; v.rb = b; v.cnd = c; v.ve = ve; v.vm = vm;
    v.sa = sa; v.sb = sb; v.de = de; v.dm = dm;
    return v;
  endfunction

  function automatic logic [63:0] mrd(logic [3:0] id);
    return (id == 4'hF) ? 64'd0 : mdl[id];
  endfunction

  task automatic expect_v(string n, logic [63:0] e);
    sb_n.push_back(n);
    sb_q.push_back(e);
  endtask

  task automatic check_v(logic [63:0] act);
    string       n;
    logic [63:0] e;
    n_vec++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: got %0h with nothing expected", act);
    end else begin
      n = sb_n.pop_front();
      e = sb_q.pop_front();
      if (act !== e) begin
        n_bad++;
        $display("FAIL %s: got %0h expected %0h", n, act, e);
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 15; i++) mdl[i] = (i == 4) ? 64'd1000 : 64'd0;
    mstat = 2'd0;
  endtask

  task automatic idle();
    in_code = 4'h1; ra = 4'hF; rb = 4'hF; cnd = 1'b0;
    flag_halt = 1'b0; in_error = 1'b0; bad_mem = 1'b0;
    val_e = '0; val_m = '0;
  endtask

  task automatic check_regs(string tag);
    for (int i = 0; i < 16; i++) begin
      dbg_sel = 4'(i);
      #1;
      expect_v($sformatf("%s_dbg%0d", tag, i), mrd(4'(i)));
      check_v(dbg_val);
    end
    expect_v({tag, "_stat"}, 64'(mstat));
    check_v(64'(stat));
  endtask

  task automatic apply_vec(int k, vec_t v);
    in_code = v.ic; ra = v.ra; rb = v.rb; cnd = v.cnd; val_e = v.ve; val_m = v.vm;
    #2;
    expect_v($sformatf("v%0d_src_a", k), 64'(v.sa)); check_v(64'(src_a));
    expect_v($sformatf("v%0d_src_b", k), 64'(v.sb)); check_v(64'(src_b));
    expect_v($sformatf("v%0d_dst_e", k), 64'(v.de)); check_v(64'(dst_e));
    expect_v($sformatf("v%0d_dst_m", k), 64'(v.dm)); check_v(64'(dst_m));
    expect_v($sformatf("v%0d_val_a", k), mrd(v.sa)); check_v(val_a);
    expect_v($sformatf("v%0d_val_b", k), mrd(v.sb)); check_v(val_b);
    @(posedge clock);
    if (mstat == 2'd0) begin
      if (v.de != 4'hF) mdl[v.de] = v.ve;
      if (v.dm != 4'hF) mdl[v.dm] = v.vm;
    end
    #1;
    idle();
    check_regs($sformatf("v%0d", k));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    model_reset();
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    idle();
    dbg_sel = 4'h0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_regs("rst");
    reset = 1'b0;
    step();

    vecs.push_back(mk(4'h3, 4'hF, 4'h2, 0, 64'd16, 0,   4'hF, 4'hF, 4'h2, 4'hF));
    vecs.push_back(mk(4'h3, 4'hF, 4'h0, 0, 64'd5,  0,   4'hF, 4'hF, 4'h0, 4'hF));
    vecs.push_back(mk(4'h3, 4'hF, 4'h3, 0, 64'd12, 0,   4'hF, 4'hF, 4'h3, 4'hF));
    vecs.push_back(mk(4'h6, 4'h0, 4'h3, 0, 64'd17, 0,   4'h0, 4'h3, 4'h3, 4'hF));
    vecs.push_back(mk(4'h2, 4'h1, 4'h5, 0, 64'd99, 0,   4'h1, 4'hF, 4'hF, 4'hF));
    vecs.push_back(mk(4'h2, 4'h1, 4'h5, 1, 64'd7,  0,   4'h1, 4'hF, 4'h5, 4'hF));
    vecs.push_back(mk(4'h4, 4'h3, 4'h2, 0, 64'd33, 0,   4'h3, 4'h2, 4'hF, 4'hF));
    vecs.push_back(mk(4'h5, 4'h6, 4'h0, 0, 64'd44, 77,  4'hF, 4'h0, 4'hF, 4'h6));
    vecs.push_back(mk(4'hA, 4'h5, 4'hF, 0, 64'd992, 0,  4'h5, 4'h4, 4'h4, 4'hF));
    vecs.push_back(mk(4'h8, 4'hF, 4'hF, 0, 64'd984, 0,  4'hF, 4'h4, 4'h4, 4'hF));
    vecs.push_back(mk(4'h9, 4'hF, 4'hF, 0, 64'd992, 55, 4'h4, 4'h4, 4'h4, 4'hF));
    vecs.push_back(mk(4'hB, 4'h7, 4'hF, 0, 64'd1000, 64'hDEADBEEF_CAFEF00D, 4'h4, 4'h4, 4'h4, 4'h7));
    vecs.push_back(mk(4'hB, 4'h4, 4'hF, 0, 64'd1008, 64'd42, 4'h4, 4'h4, 4'h4, 4'h4));
    vecs.push_back(mk(4'h7, 4'h1, 4'h2, 1, 64'd3,  64'd4, 4'hF, 4'hF, 4'hF, 4'hF));
    vecs.push_back(mk(4'h1, 4'h1, 4'h2, 1, 64'd3,  64'd4, 4'hF, 4'hF, 4'hF, 4'hF));
    vecs.push_back(mk(4'h3, 4'hF, 4'hE, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 4'hF, 4'hF, 4'hE, 4'hF));
    vecs.push_back(mk(4'h6, 4'hE, 4'hE, 0, 64'd1, 0,    4'hE, 4'hE, 4'hE, 4'hF));
    vecs.push_back(mk(4'h6, 4'hF, 4'hF, 0, 64'd9, 0,    4'hF, 4'hF, 4'hF, 4'hF));

    foreach (vecs[k]) apply_vec(k, vecs[k]);

    // halt: no write from the halting instruction, then frozen
    in_code = 4'h0; flag_halt = 1'b1; rb = 4'h2; val_e = 64'h11;
    step();
    idle();
    mstat = 2'd1;
    check_regs("halt");
    in_code = 4'h3; rb = 4'h2; val_e = 64'h55;
    step();
    idle();
    check_regs("halt_irmov");
    in_code = 4'h6; ra = 4'h0; rb = 4'h3;
    #1;
    expect_v("halt_live_val_a", mdl[0]); check_v(val_a);
    expect_v("halt_live_val_b", mdl[3]); check_v(val_b);
    bad_mem = 1'b1;
    step();
    idle();
    expect_v("halt_sticky", 64'd1); check_v(64'(stat));

    // reset mid-halt: async clear
    reset = 1'b1;
    #1;
    model_reset();
    check_regs("rst_mid");
    reset = 1'b0;
    step();

    in_code = 4'hC;
    step();
    idle();
    expect_v("ins_code_c", 64'd3); check_v(64'(stat));
    do_reset();

    in_code = 4'hC; bad_mem = 1'b1;
    step();
    idle();
    expect_v("adr_over_ins", 64'd2); check_v(64'(stat));
    do_reset();

    in_code = 4'h3; rb = 4'h2; val_e = 64'h99; in_error = 1'b1; flag_halt = 1'b1;
    step();
    idle();
    mstat = 2'd3;
    check_regs("ins_nowrite");
    do_reset();

    in_code = 4'h3; rb = 4'h2; val_e = 64'h99; bad_mem = 1'b1;
    step();
    idle();
    mstat = 2'd2;
    check_regs("adr_nowrite");
    do_reset();

    // reset held across an edge overrides the pending write
    in_code = 4'h3; rb = 4'h2; val_e = 64'h77;
    reset = 1'b1;
    step();
    idle();
    model_reset();
    check_regs("rst_override");
    reset = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
